if_id_bubble_reg: RTL and testbench
===================================

Name: if_id_bubble_reg

Overview:
- IF/ID pipeline register for the 5-stage pipelined CPU. It is the consumer of the bubble/flush request produced by the jump/branch bubble generator.
- Latches fetched PC/IR each cycle. It holds on a load-use stall and inserts a NOP bubble when a flush is requested.
- Keeps bubble, stall and redirect statistics counters for the FPGA display.

Parameters:
- DW, 32, width of PC and IR fields
- CNT_W, 32, width of each statistics counter (saturating)
- NOP, 32'h0000_0000, instruction word injected on a bubble

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  CPU halted (syscall/halt); freezes register and counters
- stall  in  1  load-use hold request from hazard unit
- j_bub  in  1  flush request from jump/branch bubble generator; every asserted cycle inserts a bubble
- pc_in  in  DW  PC of the instruction being fetched
- ir_in  in  DW  fetched instruction word
- pc_out  out  DW  registered PC to ID
- ir_out  out  DW  registered instruction to ID
- valid_out  out  1  1 = real instruction in ID, 0 = bubble
- flushed  out  1  registered: 1 for the cycle after a flush was applied
- bub_cnt  out  CNT_W  cycles in which a bubble was inserted
- stall_cnt  out  CNT_W  cycles in which the register was held by stall
- redir_cnt  out  CNT_W  distinct redirects (rising edges of j_bub)

Behaviour:
- Reset (async, immediate): pc_out=0, ir_out=NOP, valid_out=0, flushed=0, all counters=0, internal j_bub_d=0. Reset mid-operation discards the held instruction; the first edge after deassertion behaves as a normal load.
- Per-edge priority: rst > halt > j_bub > stall > load.
- halt=1: all registers, counters and j_bub_d hold their values; flushed is forced to 0.
- j_bub=1 (not halted):
  - pc_out<=0, ir_out<=NOP, valid_out<=0, flushed<=1.
  - bub_cnt increments.
  - j_bub beats stall: a simultaneous stall is ignored and stall_cnt does not increment.
- stall=1, j_bub=0: pc_out, ir_out and valid_out hold; stall_cnt increments; flushed<=0.
- Otherwise (load): pc_out<=pc_in, ir_out<=ir_in, valid_out<=1, flushed<=0.
- Edge detection: j_bub_d<=j_bub on every non-halted edge. redir_cnt increments when j_bub & !j_bub_d.
  - Two consecutive j_bub cycles: bub_cnt += 2, redir_cnt += 1.
  - Alternating pattern 1,0,1: redir_cnt += 2.
- Counters saturate at all-ones and never wrap.
- Latency: pc_in/ir_in appear on outputs 1 cycle after a load edge. Flush takes effect at the same edge at which j_bub is sampled.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package cpu_pkg: DW, the NOP encoding, CNT_W.
- One natural sub-module: sat_counter (enable, saturating increment, async reset), instantiated three times.
- Edge detection and the priority mux stay in the top module.

Test Plan:
- Reset then load: rst 1→0, pc_in=0x0000_0004, ir_in=0x2008_0005 → next edge pc_out=0x4, ir_out=0x2008_0005, valid_out=1, all counters 0.
- Stall hold: load 0x8/0x8C09_0000, then stall=1 for 2 cycles with pc_in=0xC → pc_out stays 0x8, stall_cnt=2, bub_cnt=0.
- Single flush: j_bub=1 for 1 cycle with pc_in=0x10 → ir_out=0, valid_out=0, flushed=1 on the following cycle, bub_cnt=1, redir_cnt=1.
- Flush vs stall plus back-to-back: j_bub=1 and stall=1 for 2 consecutive cycles → both cycles bubble, bub_cnt=2, redir_cnt=1, stall_cnt=0.
- Halt freeze: halt=1 with j_bub=1 for 3 cycles → outputs and all counters unchanged, flushed=0. After halt=0, a j_bub that was already 1 before halt produces no redir_cnt increment.
- Saturation and async reset: CNT_W=4, 20 bubble cycles → bub_cnt=15. Then assert rst between edges → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and encodings for the pipelined CPU
package cpu_pkg;
  localparam int DW = 32;
  localparam int CNT_W = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/if_id_bubble_reg_if.sv
// rtl/if_id_bubble_reg_if.sv - fetch-to-decode bundle: control, fetched word, registered outputs
interface if_id_bubble_reg_if
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int CNT_W = cpu_pkg::CNT_W
);
  logic halt;
  logic stall;
  logic j_bub;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] ir_in;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] ir_out;
  logic valid_out;
  logic flushed;
  logic [CNT_W-1:0] bub_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redir_cnt;

  modport master (
    output halt, stall, j_bub, pc_in, ir_in,
    input pc_out, ir_out, valid_out, flushed, bub_cnt, stall_cnt, redir_cnt
  );

  modport slave (
    input halt, stall, j_bub, pc_in, ir_in,
    output pc_out, ir_out, valid_out, flushed, bub_cnt, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/if_id_bubble_reg_sat_counter.sv
// rtl/if_id_bubble_reg_sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/if_id_bubble_reg.sv
// rtl/if_id_bubble_reg.sv - IF/ID pipeline register with stall hold, flush bubbles and statistics
module if_id_bubble_reg
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int CNT_W = cpu_pkg::CNT_W,
  parameter logic [DW-1:0] NOP = cpu_pkg::NOP
) (
  input logic clk,
  input logic rst,
  if_id_bubble_reg_if.slave bus
);
  logic j_bub_d;
  logic bub_en;
  logic stall_en;
  logic redir_en;

  // Counter enables mirror the register priority: halt > j_bub > stall.
  assign bub_en   = !bus.halt && bus.j_bub;
  assign stall_en = !bus.halt && !bus.j_bub && bus.stall;
  assign redir_en = !bus.halt && bus.j_bub && !j_bub_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc_out    <= '0;
      bus.ir_out    <= NOP;
      bus.valid_out <= 1'b0;
      bus.flushed   <= 1'b0;
      j_bub_d       <= 1'b0;
    end else if (bus.halt) begin
      bus.flushed <= 1'b0;
    end else begin
      j_bub_d <= bus.j_bub;
      if (bus.j_bub) begin
        bus.pc_out    <= '0;
        bus.ir_out    <= NOP;
        bus.valid_out <= 1'b0;
        bus.flushed   <= 1'b1;
      end else if (bus.stall) begin
        bus.flushed <= 1'b0;
      end else begin
        bus.pc_out    <= bus.pc_in;
        bus.ir_out    <= bus.ir_in;
        bus.valid_out <= 1'b1;
        bus.flushed   <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_bub_cnt (
    .clk(clk), .rst(rst), .en(bub_en), .count(bus.bub_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .en(stall_en), .count(bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk(clk), .rst(rst), .en(redir_en), .count(bus.redir_cnt)
  );
endmodule

// File: tb/tb_if_id_bubble_reg.sv
// tb/tb_if_id_bubble_reg.sv - directed self-checking bench for if_id_bubble_reg
module tb_if_id_bubble_reg;
  logic clk;
  logic rst;
  int tests_run;
  int tests_failed;

  if_id_bubble_reg_if #(.DW(32), .CNT_W(32)) bus ();
  if_id_bubble_reg_if #(.DW(32), .CNT_W(4)) bus4 ();

  if_id_bubble_reg #(.DW(32), .CNT_W(32), .NOP(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  if_id_bubble_reg #(.DW(32), .CNT_W(4), .NOP(32'h0)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.halt = 0; bus.stall = 0; bus.j_bub = 0; bus.pc_in = 0; bus.ir_in = 0;
    bus4.halt = 0; bus4.stall = 0; bus4.j_bub = 0; bus4.pc_in = 0; bus4.ir_in = 0;
    rst = 1;
    step();
    step();
    tests_run++;
    if (bus.pc_out !== 32'h0 || bus.ir_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.flushed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: pc=%h ir=%h v=%b f=%b, want 0 0 0 0", bus.pc_out, bus.ir_out, bus.valid_out, bus.flushed);
    end
    tests_run++;
    if (bus.bub_cnt !== 0 || bus.stall_cnt !== 0 || bus.redir_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_counters: bub=%0d stall=%0d redir=%0d, want 0 0 0", bus.bub_cnt, bus.stall_cnt, bus.redir_cnt);
    end
    rst = 0;
    bus.pc_in = 32'h0000_0004; bus.ir_in = 32'h2008_0005;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h4 || bus.ir_out !== 32'h2008_0005 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_load: pc=%h ir=%h v=%b, want 4 20080005 1", bus.pc_out, bus.ir_out, bus.valid_out);
    end
    tests_run++;
    if (bus.bub_cnt !== 0 || bus.stall_cnt !== 0 || bus.redir_cnt !== 0) begin
      tests_failed++;
      $display("FAIL first_load_counters: bub=%0d stall=%0d redir=%0d, want 0 0 0", bus.bub_cnt, bus.stall_cnt, bus.redir_cnt);
    end
  endtask

  task automatic test_stall();
    bus.pc_in = 32'h8; bus.ir_in = 32'h8C09_0000;
    step();
    bus.stall = 1; bus.pc_in = 32'hC; bus.ir_in = 32'h1234_5678;
    step();
    step();
    tests_run++;
    if (bus.pc_out !== 32'h8 || bus.ir_out !== 32'h8C09_0000 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_hold: pc=%h ir=%h v=%b, want 8 8c090000 1", bus.pc_out, bus.ir_out, bus.valid_out);
    end
    tests_run++;
    if (bus.stall_cnt !== 2 || bus.bub_cnt !== 0 || bus.flushed !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_counters: stall=%0d bub=%0d f=%b, want 2 0 0", bus.stall_cnt, bus.bub_cnt, bus.flushed);
    end
    bus.stall = 0;
  endtask

  task automatic test_flush();
    bus.j_bub = 1; bus.pc_in = 32'h10; bus.ir_in = 32'hAAAA_5555;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h0 || bus.ir_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.flushed !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_flush: pc=%h ir=%h v=%b f=%b, want 0 0 0 1", bus.pc_out, bus.ir_out, bus.valid_out, bus.flushed);
    end
    tests_run++;
    if (bus.bub_cnt !== 1 || bus.redir_cnt !== 1 || bus.stall_cnt !== 2) begin
      tests_failed++;
      $display("FAIL single_flush_counters: bub=%0d redir=%0d stall=%0d, want 1 1 2", bus.bub_cnt, bus.redir_cnt, bus.stall_cnt);
    end
    bus.j_bub = 0; bus.pc_in = 32'h14; bus.ir_in = 32'h0123_4567;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h14 || bus.ir_out !== 32'h0123_4567 || bus.valid_out !== 1'b1 || bus.flushed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_after_flush: pc=%h ir=%h v=%b f=%b, want 14 01234567 1 0", bus.pc_out, bus.ir_out, bus.valid_out, bus.flushed);
    end
  endtask

  task automatic test_back_to_back();
    bus.j_bub = 1; bus.stall = 1; bus.pc_in = 32'h18; bus.ir_in = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.flushed !== 1'b1 || bus.bub_cnt !== 2 || bus.redir_cnt !== 2) begin
      tests_failed++;
      $display("FAIL b2b_first: v=%b f=%b bub=%0d redir=%0d, want 0 1 2 2", bus.valid_out, bus.flushed, bus.bub_cnt, bus.redir_cnt);
    end
    step();
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.ir_out !== 32'h0 || bus.bub_cnt !== 3 || bus.redir_cnt !== 2 || bus.stall_cnt !== 2) begin
      tests_failed++;
      $display("FAIL b2b_second: v=%b ir=%h bub=%0d redir=%0d stall=%0d, want 0 0 3 2 2",
               bus.valid_out, bus.ir_out, bus.bub_cnt, bus.redir_cnt, bus.stall_cnt);
    end
    bus.j_bub = 0; bus.stall = 0;
    step();
  endtask

  task automatic test_halt();
    // pc 0x18 / DEADBEEF is loaded; flush once so j_bub is already high entering halt
    bus.j_bub = 1;
    step();
    tests_run++;
    if (bus.bub_cnt !== 4 || bus.redir_cnt !== 3 || bus.flushed !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_halt_flush: bub=%0d redir=%0d f=%b, want 4 3 1", bus.bub_cnt, bus.redir_cnt, bus.flushed);
    end
    bus.halt = 1; bus.pc_in = 32'h40; bus.ir_in = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (bus.pc_out !== 32'h0 || bus.ir_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.flushed !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_outputs: pc=%h ir=%h v=%b f=%b, want 0 0 0 0", bus.pc_out, bus.ir_out, bus.valid_out, bus.flushed);
    end
    tests_run++;
    if (bus.bub_cnt !== 4 || bus.redir_cnt !== 3 || bus.stall_cnt !== 2) begin
      tests_failed++;
      $display("FAIL halt_counters: bub=%0d redir=%0d stall=%0d, want 4 3 2", bus.bub_cnt, bus.redir_cnt, bus.stall_cnt);
    end
    bus.halt = 0;
    step();
    tests_run++;
    if (bus.bub_cnt !== 5 || bus.redir_cnt !== 3 || bus.flushed !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_halt_no_redir: bub=%0d redir=%0d f=%b, want 5 3 1", bus.bub_cnt, bus.redir_cnt, bus.flushed);
    end
    bus.j_bub = 0; bus.pc_in = 32'h44; bus.ir_in = 32'h0000_1111;
    step();
    bus.halt = 1; bus.pc_in = 32'h48; bus.ir_in = 32'h2222_3333;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h44 || bus.ir_out !== 32'h0000_1111 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_holds_load: pc=%h ir=%h v=%b, want 44 00001111 1", bus.pc_out, bus.ir_out, bus.valid_out);
    end
    bus.halt = 0;
  endtask

  task automatic test_saturation_async_reset();
    bus4.j_bub = 1;
    for (int i = 0; i < 20; i++) step();
    tests_run++;
    if (bus4.bub_cnt !== 4'd15 || bus4.redir_cnt !== 4'd1 || bus4.stall_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL saturation: bub=%0d redir=%0d stall=%0d, want 15 1 0", bus4.bub_cnt, bus4.redir_cnt, bus4.stall_cnt);
    end
    bus4.j_bub = 0;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h48 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_load: pc=%h v=%b, want 48 1", bus.pc_out, bus.valid_out);
    end
    #2;
    rst = 1;
    #1;
    tests_run++;
    if (bus.pc_out !== 32'h0 || bus.ir_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.flushed !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: pc=%h ir=%h v=%b f=%b, want 0 0 0 0", bus.pc_out, bus.ir_out, bus.valid_out, bus.flushed);
    end
    tests_run++;
    if (bus.bub_cnt !== 0 || bus.stall_cnt !== 0 || bus.redir_cnt !== 0 || bus4.bub_cnt !== 0 || bus4.redir_cnt !== 0) begin
      tests_failed++;
      $display("FAIL async_reset_counters: bub=%0d stall=%0d redir=%0d bub4=%0d redir4=%0d, want all 0",
               bus.bub_cnt, bus.stall_cnt, bus.redir_cnt, bus4.bub_cnt, bus4.redir_cnt);
    end
    step();
    rst = 0;
    bus.pc_in = 32'h100; bus.ir_in = 32'h0BAD_F00D;
    step();
    tests_run++;
    if (bus.pc_out !== 32'h100 || bus.ir_out !== 32'h0BAD_F00D || bus.valid_out !== 1'b1 || bus.redir_cnt !== 0) begin
      tests_failed++;
      $display("FAIL load_after_reset: pc=%h ir=%h v=%b redir=%0d, want 100 0badf00d 1 0",
               bus.pc_out, bus.ir_out, bus.valid_out, bus.redir_cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_stall();
    test_flush();
    test_back_to_back();
    test_halt();
    test_saturation_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
